// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Handshake: a request is accepted in any cycle where req and gnt are both 1; exactly one rvalid follows for it.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// It allows one outstanding imem request at a time, and takes redirects from EX and stalls from the hazard unit.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        if_id_instr,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] hold_q;
  logic        kill_q;
  logic        req_q;

  logic [31:0] redir_pc;
  logic        load_en;
  logic [31:0] load_word;

  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign imem.req  = req_q;
  assign imem.addr = {pc_q[31:2], 2'b00};
  assign dbg_state = state_q;

  // IF/ID takes a fresh response directly, or the parked word once the stall clears.
  always_comb begin
    load_en   = 1'b0;
    load_word = hold_q;
    if (!stall && !redirect_valid) begin
      if (state_q == WAIT && imem.rvalid && !kill_q) begin
        load_en   = 1'b1;
        load_word = imem.rdata;
      end else if (state_q == HOLD) begin
        load_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      hold_q      <= NOP_INSTR;
      kill_q      <= 1'b0;
      req_q       <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd4;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (redirect_valid) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (!stall) begin
        if (load_en) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= req_pc_q;
          if_id_pc4   <= req_pc_q + 32'd4;
          if_id_instr <= load_word;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end

      case (state_q)
        BOOT: begin
          state_q <= REQ;
          req_q   <= !stall;
          if (redirect_valid) pc_q <= redir_pc;
        end
        REQ: begin
          if (req_q && imem.gnt) begin
            // The request is already accepted; a simultaneous redirect must discard its response.
            state_q  <= WAIT;
            req_q    <= 1'b0;
            req_pc_q <= pc_q;
            kill_q   <= redirect_valid;
            pc_q     <= redirect_valid ? redir_pc : pc_q + 32'd4;
          end else begin
            req_q <= !stall;
            if (redirect_valid) pc_q <= redir_pc;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            kill_q <= 1'b0;
            if (redirect_valid) pc_q <= redir_pc;
            if (!kill_q && !redirect_valid && stall) begin
              hold_q  <= imem.rdata;
              state_q <= HOLD;
            end else begin
              state_q <= REQ;
              req_q   <= !stall;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
            pc_q   <= redir_pc;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            state_q <= REQ;
            req_q   <= !stall;
            if (redirect_valid) pc_q <= redir_pc;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency imem model plus a program-order reference monitor.
// Directed scenario tasks run in sequence, followed by a randomized run.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n          = 1'b0;
  logic        stall          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'd0;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic [1:0]  dbg_state;

  logic        rst2_n = 1'b0;
  logic        stall2 = 1'b0;
  logic        rd2    = 1'b0;
  logic [31:0] rpc2   = 32'd0;
  logic        v2;
  logic [31:0] pc2, pc42, instr2;
  logic [1:0]  dbg2;

  fetch_stage_if imem_bus ();
  fetch_stage_if imem_bus2 ();

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem(imem_bus), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .dbg_state(dbg_state)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem(imem_bus2), .stall(stall2),
    .redirect_valid(rd2), .redirect_pc(rpc2),
    .if_id_valid(v2), .if_id_pc(pc2), .if_id_pc4(pc42),
    .if_id_instr(instr2), .dbg_state(dbg2)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  int unsigned gnt_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  logic [31:0] gnt_q[$];
  logic [31:0] load_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] g2_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  // imem model for dut: random grant, one outstanding, random latency >= 1
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  always @(negedge clk) begin
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    if (busy) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        busy            = 1'b0;
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = mem_word(pend_addr);
      end
    end
    if (imem_bus.req === 1'b1 && !busy && $urandom_range(99) < gnt_pct) begin
      imem_bus.gnt = 1'b1;
      busy         = 1'b1;
      cnt          = int'($urandom_range(lat_max, lat_min));
      pend_addr    = imem_bus.addr;
      gnt_q.push_back(imem_bus.addr);
    end
  end

  // imem model for dut2: always ready, one-cycle latency
  logic        pend2 = 1'b0;
  logic [31:0] paddr2 = 32'd0;
  always @(negedge clk) begin
    imem_bus2.rvalid = pend2;
    imem_bus2.rdata  = mem_word(paddr2);
    imem_bus2.gnt    = 1'b0;
    pend2            = 1'b0;
    if (imem_bus2.req === 1'b1) begin
      imem_bus2.gnt = 1'b1;
      pend2         = 1'b1;
      paddr2        = imem_bus2.addr;
      g2_q.push_back(imem_bus2.addr);
    end
  end

  // Reference monitor: IF/ID must follow program order from the last reset/redirect target.
  logic [31:0] exp_pc = 32'd0;
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = 32'd0, last_pc4 = 32'd4, last_instr = NOP;
  always @(posedge clk) begin : mon
    logic        s_rst, s_st, s_rd;
    logic [31:0] s_rpc;
    s_rst = rst_n;
    s_st  = stall;
    s_rd  = redirect_valid;
    s_rpc = redirect_pc;
    #1;
    vec_cnt++;
    if (!s_rst) begin
      if (if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_pc4 !== 32'd4 ||
          if_id_instr !== NOP || imem_bus.req !== 1'b0 || imem_bus.addr !== 32'd0) begin
        err_cnt++;
        $display("FAIL mon_reset: got valid=%b pc=%h pc4=%h instr=%h req=%b addr=%h, want 0/0/4/%h/0/0",
                 if_id_valid, if_id_pc, if_id_pc4, if_id_instr, imem_bus.req, imem_bus.addr, NOP);
      end
      exp_pc = 32'd0;
    end else if (s_rd) begin
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== last_pc || if_id_pc4 !== last_pc4) begin
        err_cnt++;
        $display("FAIL mon_flush: got valid=%b instr=%h pc=%h pc4=%h, want 0/%h/%h/%h",
                 if_id_valid, if_id_instr, if_id_pc, if_id_pc4, NOP, last_pc, last_pc4);
      end
      exp_pc = s_rpc & 32'hFFFF_FFFC;
    end else if (s_st) begin
      if (if_id_valid !== last_valid || if_id_pc !== last_pc || if_id_pc4 !== last_pc4 || if_id_instr !== last_instr) begin
        err_cnt++;
        $display("FAIL mon_stall_hold: got %b/%h/%h/%h, want %b/%h/%h/%h", if_id_valid, if_id_pc,
                 if_id_pc4, if_id_instr, last_valid, last_pc, last_pc4, last_instr);
      end
    end else if (if_id_valid === 1'b1) begin
      if (if_id_pc !== exp_pc || if_id_pc4 !== exp_pc + 32'd4 || if_id_instr !== mem_word(exp_pc)) begin
        err_cnt++;
        $display("FAIL mon_load: got pc=%h pc4=%h instr=%h, want %h/%h/%h", if_id_pc, if_id_pc4,
                 if_id_instr, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
      end
      load_q.push_back(if_id_pc);
      instr_q.push_back(if_id_instr);
      exp_pc = exp_pc + 32'd4;
    end else begin
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
        err_cnt++;
        $display("FAIL mon_bubble: got valid=%b instr=%h, want 0/%h", if_id_valid, if_id_instr, NOP);
      end
    end
    if (imem_bus.req === 1'b1) begin
      vec_cnt++;
      if (imem_bus.addr[1:0] !== 2'b00) begin
        err_cnt++;
        $display("FAIL mon_addr_align: got addr=%h, want low bits 00", imem_bus.addr);
      end
    end
    last_valid = if_id_valid;
    last_pc    = if_id_pc;
    last_pc4   = if_id_pc4;
    last_instr = if_id_instr;
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    gnt_q.delete();
    load_q.delete();
    instr_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_pc4 !== 32'd4 || if_id_instr !== NOP) begin
      err_cnt++;
      $display("FAIL reset_ifid: got %b/%h/%h/%h, want 0/0/4/%h", if_id_valid, if_id_pc, if_id_pc4, if_id_instr, NOP);
    end
    vec_cnt++;
    if (imem_bus.req !== 1'b0 || imem_bus.addr !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_imem: got req=%b addr=%h, want 0/0", imem_bus.req, imem_bus.addr);
    end
  endtask

  task automatic test_sequential();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(3);
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'd0 || if_id_pc4 !== 32'd4) begin
      err_cnt++;
      $display("FAIL seq_first: got %b/%h/%h, want 1/0/4", if_id_valid, if_id_pc, if_id_pc4);
    end
    @(negedge clk);
    vec_cnt++;
    if (if_id_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL seq_bubble: got valid=%b, want 0", if_id_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'd4 || if_id_pc4 !== 32'd8) begin
      err_cnt++;
      $display("FAIL seq_second: got %b/%h/%h, want 1/4/8", if_id_valid, if_id_pc, if_id_pc4);
    end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'd8 || if_id_pc4 !== 32'd12) begin
      err_cnt++;
      $display("FAIL seq_third: got %b/%h/%h, want 1/8/c", if_id_valid, if_id_pc, if_id_pc4);
    end
    exp_q = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (i >= gnt_q.size() || gnt_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL seq_addr[%0d]: got %h, want %h", i, (i < gnt_q.size()) ? gnt_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit done;
    int n8;
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    do_reset(4);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (gnt_q.size() >= 3) done = 1;
    end
    vec_cnt++;
    if (!done || gnt_q[2] !== 32'h8) begin
      err_cnt++;
      $display("FAIL rdw_gnt8: got done=%0d addr=%h, want 1/8", done, done ? gnt_q[2] : 32'hx);
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (load_q.size() >= 3) done = 1;
    end
    vec_cnt++;
    if (gnt_q.size() < 4 || gnt_q[3] !== 32'h100) begin
      err_cnt++;
      $display("FAIL rdw_next_addr: got %h, want 100", (gnt_q.size() >= 4) ? gnt_q[3] : 32'hx);
    end
    n8 = 0;
    foreach (load_q[i]) if (load_q[i] == 32'h8) n8++;
    vec_cnt++;
    if (n8 != 0) begin
      err_cnt++;
      $display("FAIL rdw_dropped: got %0d loads of pc 8, want 0", n8);
    end
    exp_q = '{32'h0, 32'h4, 32'h100};
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (i >= load_q.size() || load_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL rdw_order[%0d]: got %h, want %h", i, (i < load_q.size()) ? load_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    bit done;
    int n8;
    mem_ovr[32'h8] = 32'h00A0_0093;
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    do_reset(5);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (gnt_q.size() >= 3) done = 1;
    end
    @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (imem_bus.req !== 1'b0 || load_q.size() != 2) begin
      err_cnt++;
      $display("FAIL sth_frozen: got req=%b loads=%0d, want 0/2", imem_bus.req, load_q.size());
    end
    @(negedge clk);
    stall = 1'b0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (load_q.size() >= 4) done = 1;
    end
    n8 = 0;
    foreach (load_q[i]) if (load_q[i] == 32'h8) begin
      n8++;
      vec_cnt++;
      if (instr_q[i] !== 32'h00A0_0093) begin
        err_cnt++;
        $display("FAIL sth_instr: got %h, want 00a00093", instr_q[i]);
      end
    end
    vec_cnt++;
    if (n8 != 1) begin
      err_cnt++;
      $display("FAIL sth_once: got %0d loads of pc 8, want 1", n8);
    end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (i >= load_q.size() || load_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL sth_order[%0d]: got %h, want %h", i, (i < load_q.size()) ? load_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_stall();
    bit done;
    logic [31:0] saved_pc;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(4);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (if_id_valid === 1'b1) done = 1;
    end
    vec_cnt++;
    if (!done) begin
      err_cnt++;
      $display("FAIL rds_no_valid: got no valid IF/ID in 40 cycles, want one");
    end
    saved_pc       = if_id_pc;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    load_q.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    vec_cnt++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== saved_pc) begin
      err_cnt++;
      $display("FAIL rds_flush: got %b/%h/%h, want 0/%h/%h", if_id_valid, if_id_instr, if_id_pc, NOP, saved_pc);
    end
    @(negedge clk);
    stall = 1'b0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (load_q.size() >= 1) done = 1;
    end
    vec_cnt++;
    if (!done || load_q[0] !== 32'h40) begin
      err_cnt++;
      $display("FAIL rds_target: got %h, want 40", done ? load_q[0] : 32'hx);
    end
  endtask

  task automatic test_reset_pc();
    bit done;
    @(negedge clk);
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    g2_q.delete();
    rst2_n = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (v2 === 1'b1 && pc2 === 32'hFFFF_FFFC) done = 1;
    end
    vec_cnt++;
    if (!done || pc42 !== 32'h0 || instr2 !== mem_word(32'hFFFF_FFFC)) begin
      err_cnt++;
      $display("FAIL rpc_wrap_load: got done=%0d pc4=%h instr=%h, want 1/0/%h", done, pc42, instr2, mem_word(32'hFFFF_FFFC));
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (g2_q.size() < 2 || g2_q[0] !== 32'hFFFF_FFFC || g2_q[1] !== 32'h0) begin
      err_cnt++;
      $display("FAIL rpc_addrs: got %h,%h, want fffffffc,0", (g2_q.size() > 0) ? g2_q[0] : 32'hx,
               (g2_q.size() > 1) ? g2_q[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    gnt_pct = 100; lat_min = 6; lat_max = 6;
    do_reset(8);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (gnt_q.size() >= 2) done = 1;
    end
    rst_n = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk);
    gnt_q.delete();
    load_q.delete();
    instr_q.delete();
    rst_n = 1'b1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (load_q.size() >= 1) done = 1;
    end
    vec_cnt++;
    if (!done || load_q[0] !== 32'h0 || instr_q[0] !== mem_word(32'h0)) begin
      err_cnt++;
      $display("FAIL rmid_first: got done=%0d pc=%h instr=%h, want 1/0/%h", done,
               done ? load_q[0] : 32'hx, done ? instr_q[0] : 32'hx, mem_word(32'h0));
    end
    vec_cnt++;
    if (gnt_q.size() < 1 || gnt_q[0] !== 32'h0) begin
      err_cnt++;
      $display("FAIL rmid_addr: got %h, want 0", (gnt_q.size() > 0) ? gnt_q[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    do_reset(4);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      stall          = ($urandom_range(99) < 20);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = $urandom & 32'h0000_0FFF;
    end
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    vec_cnt++;
    if (load_q.size() <= 30) begin
      err_cnt++;
      $display("FAIL rnd_progress: got %0d loads, want more than 30", load_q.size());
    end
  endtask

  initial begin
    imem_bus.gnt     = 1'b0;
    imem_bus.rvalid  = 1'b0;
    imem_bus.rdata   = 32'd0;
    imem_bus2.gnt    = 1'b0;
    imem_bus2.rvalid = 1'b0;
    imem_bus2.rdata  = 32'd0;
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_stall_hold();
    test_redirect_stall();
    test_reset_pc();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within 300000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
